operand_fetch: RTL
==================

# operand_fetch

Decode/operand-fetch stage of the RISC-V core. It sits directly upstream of the register file and drives its two read ports. It also tracks pending destination writes in a 32-entry scoreboard and forwards same-cycle writeback data. Fetched instructions are registered with their operand values and handed to the execute stage over a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, data and PC width.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; sampled only on the rising edge of clk.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  RV32I instruction word.
- in_pc  in  XLEN  instruction PC.
- rf_rd_en1 / rf_rd_en2  out  1  register file read enables.
- rf_rd_index1 / rf_rd_index2  out  5  register file read indices (rs1 / rs2 field).
- rf_rd_data1 / rf_rd_data2  in  XLEN  combinational register file read data.
- wb_valid  in  1  writeback commits this cycle (same edge as the register file write).
- wb_index  in  5  writeback destination.
- wb_data  in  XLEN  writeback value.
- flush  in  1  discard the held output instruction.
- out_valid  out  1  output holds a valid instruction.
- out_ready  in  1  execute stage accepts.
- out_pc, out_instr  out  XLEN, 32  registered copy of the accepted instruction.
- out_rs1_val, out_rs2_val  out  XLEN  resolved operands.
- out_rd  out  5  destination index.
- out_rd_we  out  1  instruction writes a nonzero rd.

## Operation
- Opcode decode, on in_instr[6:0]:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - rd written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, only when rd != 0.
  - Any other opcode uses no sources and writes nothing.
- Read ports:
  - rf_rd_enN = in_valid && source used.
  - Unused source: operand value 0.
  - Source index 0: operand value 0, and it is never treated as busy.
- Forwarding: if wb_valid and wb_index equals a used nonzero source, the operand takes wb_data instead of rf_rd_dataN.
- Scoreboard: busy[31:1]; busy[0] is hardwired 0.
  - A used source stalls if busy and not forwarded this cycle.
  - rd stalls if out_rd_we and busy[rd] and not cleared by wb this cycle (WAW stall).
- Output register is a single slot: free when !out_valid or out_ready.
- in_ready = slot free && !hazard && !flush.
- Accept (in_valid && in_ready):
  - Load all out_* fields; set out_valid.
  - If out_rd_we, set busy[rd].
- wb_valid clears busy[wb_index].
  - Set and clear on the same index in the same cycle: set wins.
- Out handshake with no accept in the same cycle: out_valid clears next edge.
- flush:
  - Next edge, out_valid=0.
  - If the held instruction had out_rd_we, release its busy bit.
  - No accept occurs that cycle; the input is dropped (upstream flushes too).
- Reset (reset=0 at an edge):
  - out_valid=0; all out_* data=0; busy all 0.
  - in_ready evaluates to 1 while slot free; the combinational outputs follow inputs.
- Reset asserted mid-stall or mid-handshake: the held instruction is dropped with no writeback required.

## Timing
- Latency: 1 cycle from accept edge to out_valid.
- Throughput: 1 instruction per cycle with no hazard and out_ready=1.
- RAW dependency on an in-flight producer: stall until the cycle wb_valid presents that index. Accept occurs in that same cycle with the forwarded value (0 bubble after writeback).
- out_* stays stable while out_valid && !out_ready.
- rf_rd_* outputs are combinational from in_instr/in_valid. rf_rd_dataN is consumed the same cycle.

## Test plan
- Reset: hold reset=0 for 2 cycles, then 1 -> out_valid=0, out_rs1_val=0, busy empty, in_ready=1 with out_ready=0.
- Back-to-back independent: 0x00500093 (addi x1,x0,5) then 0x00700113 (addi x2,x0,7), out_ready=1 -> out_valid on consecutive cycles; out_rd=1 then 2; out_rd_we=1; both rs1 values 0.
- RAW stall plus forward: addi x1 accepted, then 0x002081B3 (add x3,x1,x2) -> in_ready=0 until wb_valid=1, wb_index=1, wb_data=0x5. Accepted that cycle; out_rs1_val=0x5; rs2 equals rf_rd_data2.
- x0 handling: 0x00000033 (add x0,x0,x0) with rf_rd_data1=0xDEADBEEF -> out_rs1_val=0; out_rd_we=0; no busy bit set.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> out_* unchanged and in_ready=0 throughout. out_ready=1 -> next instruction loads the following cycle.
- Flush: addi x4,x0,1 (0x00100213) held with out_ready=0, flush=1 -> out_valid=0 next cycle; busy[4] released. An immediately following add reading x4 is accepted without any wb_valid.

Source files
------------

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: drives the register file read ports, resolves
// operands with writeback forwarding, tracks pending writes, and registers the result.
module operand_fetch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            rf_rd_en1,
  output logic            rf_rd_en2,
  output logic [4:0]      rf_rd_index1,
  output logic [4:0]      rf_rd_index2,
  input  logic [XLEN-1:0] rf_rd_data1,
  input  logic [XLEN-1:0] rf_rd_data2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_index,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [4:0]      out_rd,
  output logic            out_rd_we
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready may depend on in_valid; out_* is held stable while out_valid && !out_ready.

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [4:0]      rs1, rs2, rd;
  logic            use_rs1, use_rs2, writes_rd, dec_rd_we;
  logic            fwd1, fwd2, stall1, stall2, waw, hazard;
  logic            slot_free, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [31:0]     busy, busy_next;

  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd  = in_instr[11:7];

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    case (in_instr[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_OP: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign dec_rd_we = writes_rd && (rd != 5'd0);

  assign rf_rd_en1    = in_valid && use_rs1;
  assign rf_rd_en2    = in_valid && use_rs2;
  assign rf_rd_index1 = rs1;
  assign rf_rd_index2 = rs2;

  assign fwd1 = use_rs1 && (rs1 != 5'd0) && wb_valid && (wb_index == rs1);
  assign fwd2 = use_rs2 && (rs2 != 5'd0) && wb_valid && (wb_index == rs2);

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (use_rs1 && rs1 != 5'd0) rs1_val = fwd1 ? wb_data : rf_rd_data1;
    if (use_rs2 && rs2 != 5'd0) rs2_val = fwd2 ? wb_data : rf_rd_data2;
  end

  // busy[0] is always 0, so x0 never stalls.
  assign stall1 = use_rs1 && busy[rs1] && !fwd1;
  assign stall2 = use_rs2 && busy[rs2] && !fwd2;
  assign waw    = dec_rd_we && busy[rd] && !(wb_valid && wb_index == rd);
  assign hazard = in_valid && (stall1 || stall2 || waw);

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard && !flush;
  assign accept    = in_valid && in_ready;

  // Clears are applied before the set so a same-index set wins.
  always_comb begin
    busy_next = busy;
    if (wb_valid) busy_next[wb_index] = 1'b0;
    if (flush && out_valid && out_rd_we) busy_next[out_rd] = 1'b0;
    if (accept && dec_rd_we) busy_next[rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_instr   <= in_instr;
      out_rs1_val <= rs1_val;
      out_rs2_val <= rs2_val;
      out_rd      <= rd;
      out_rd_we   <= dec_rd_we;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
